// File: rtl/fifo_gen.sv
// Synchronous circular-buffer FIFO with strobe/busy write and FWFT strobe/ack read, count, flags, flush, sticky errors.
// Latency: a word pushed at edge n is at FO_DAT with FO_STB=1 after edge n; one push and one pop per cycle.
// Backpressure: FI_BSY is high when full and refuses the write even if a pop happens in the same cycle.
module fifo_gen #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int AFULL  = DEPTH - 4,
  parameter int AEMPTY = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FLUSH,
  input  logic                       FI_STB,
  input  logic [WIDTH-1:0]           FI_DAT,
  output logic                       FI_BSY,
  output logic                       FI_AFULL,
  output logic                       FO_STB,
  output logic [WIDTH-1:0]           FO_DAT,
  input  logic                       FO_ACK,
  output logic                       FO_AEMPTY,
  output logic [$clog2(DEPTH):0]     FO_CNT,
  output logic                       ERR_OVF,
  output logic                       ERR_UNF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             err_ovf;
  logic             err_unf;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status decoded from the registered count only, so no input reaches an output combinationally.
  always_comb begin
    full  = (count == DEPTH_C);
    empty = (count == '0);
    push  = FI_STB & ~full;
    pop   = FO_ACK & ~empty;
  end

  // Pointers, occupancy and sticky error flags; reset beats flush, flush discards same-cycle push/pop.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (FI_STB && full)  err_ovf <= 1'b1;
      if (FO_ACK && empty) err_unf <= 1'b1;
    end
  end

  // Storage array; contents are not cleared by reset or flush, only the pointers are.
  always_ff @(posedge CLK) begin
    if (push && !RST && !FLUSH) mem[wr_ptr] <= FI_DAT;
  end

  // Head data is forced to zero while empty so the post-reset value is defined without clearing the array.
  always_comb begin
    FO_DAT    = empty ? '0 : mem[rd_ptr];
    FO_STB    = ~empty;
    FI_BSY    = full;
    FI_AFULL  = (count >= AFULL_C);
    FO_AEMPTY = (count <= AEMPTY_C);
    FO_CNT    = count;
    ERR_OVF   = err_ovf;
    ERR_UNF   = err_unf;
  end

endmodule

// File: tb/tb_fifo_gen.sv
// Self-checking bench for fifo_gen (WIDTH=8, DEPTH=16, AFULL=12, AEMPTY=2).
// Directed scenarios plus a randomized run compared against a queue-based model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_fifo_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       FLUSH = 1'b0;
  logic       FI_STB = 1'b0;
  logic [7:0] FI_DAT = 8'h00;
  logic       FI_BSY;
  logic       FI_AFULL;
  logic       FO_STB;
  logic [7:0] FO_DAT;
  logic       FO_ACK = 1'b0;
  logic       FO_AEMPTY;
  logic [4:0] FO_CNT;
  logic       ERR_OVF;
  logic       ERR_UNF;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of stored words plus sticky error bits.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  fifo_gen #(.WIDTH(8), .DEPTH(16), .AFULL(12), .AEMPTY(2)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .FI_STB(FI_STB), .FI_DAT(FI_DAT), .FI_BSY(FI_BSY), .FI_AFULL(FI_AFULL),
    .FO_STB(FO_STB), .FO_DAT(FO_DAT), .FO_ACK(FO_ACK), .FO_AEMPTY(FO_AEMPTY),
    .FO_CNT(FO_CNT), .ERR_OVF(ERR_OVF), .ERR_UNF(ERR_UNF)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle, advance the model across the edge, then settle 1 unit past it.
  task automatic step(input logic rst_i, input logic flush_i, input logic stb_i,
                      input logic [7:0] dat_i, input logic ack_i);
    bit was_full;
    bit was_empty;
    RST = rst_i; FLUSH = flush_i; FI_STB = stb_i; FI_DAT = dat_i; FO_ACK = ack_i;
    @(posedge CLK);
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    if (rst_i || flush_i) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (stb_i && was_full)  m_ovf = 1'b1;
      if (ack_i && was_empty) m_unf = 1'b1;
      if (ack_i && !was_empty) void'(q.pop_front());
      if (stb_i && !was_full)  q.push_back(dat_i);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    checks++;
    if ({FI_BSY, FI_AFULL, FO_STB, FO_AEMPTY, ERR_OVF, ERR_UNF} !== 6'b000100) begin
      failures++;
      $display("FAIL reset_flags: got bsy/afull/stb/aempty/ovf/unf=%b expected 000100",
               {FI_BSY, FI_AFULL, FO_STB, FO_AEMPTY, ERR_OVF, ERR_UNF});
    end
    checks++;
    if (FO_CNT !== 5'd0) begin
      failures++; $display("FAIL reset_cnt: got %0d expected 0", FO_CNT);
    end
    checks++;
    if (FO_DAT !== 8'h00) begin
      failures++; $display("FAIL reset_dat: got %0h expected 0", FO_DAT);
    end
  endtask

  task automatic test_fill_overflow();
    int n;
    for (int i = 1; i <= 21; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
      n = (i > 16) ? 16 : i;
      checks++;
      if (FO_CNT !== 5'(n)) begin
        failures++; $display("FAIL fill_cnt[%0d]: got %0d expected %0d", i, FO_CNT, n);
      end
      checks++;
      if (FI_AFULL !== (i >= 12)) begin
        failures++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, FI_AFULL, i >= 12);
      end
      checks++;
      if (FI_BSY !== (i >= 16)) begin
        failures++; $display("FAIL fill_bsy[%0d]: got %b expected %b", i, FI_BSY, i >= 16);
      end
      checks++;
      if (ERR_OVF !== (i >= 17)) begin
        failures++; $display("FAIL fill_ovf[%0d]: got %b expected %b", i, ERR_OVF, i >= 17);
      end
    end
  endtask

  task automatic test_drain();
    int n;
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) begin
        checks++;
        if (FO_STB !== 1'b1 || FO_DAT !== 8'(k)) begin
          failures++;
          $display("FAIL drain_head[%0d]: got stb=%b dat=%0d expected stb=1 dat=%0d", k, FO_STB, FO_DAT, k);
        end
      end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      n = (k > 16) ? 0 : 16 - k;
      checks++;
      if (FO_CNT !== 5'(n) || FO_STB !== (n != 0)) begin
        failures++;
        $display("FAIL drain_cnt[%0d]: got cnt=%0d stb=%b expected cnt=%0d stb=%b", k, FO_CNT, FO_STB, n, n != 0);
      end
      checks++;
      if (FO_AEMPTY !== (n <= 2)) begin
        failures++; $display("FAIL drain_aempty[%0d]: got %b expected %b", k, FO_AEMPTY, n <= 2);
      end
      checks++;
      if (ERR_UNF !== (k == 17)) begin
        failures++; $display("FAIL drain_unf[%0d]: got %b expected %b", k, ERR_UNF, k == 17);
      end
    end
  endtask

  task automatic test_streaming();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
    for (int i = 1; i <= 255; i++) begin
      checks++;
      if (FO_CNT !== 5'd1 || FO_DAT !== 8'(i - 1) || ERR_OVF !== 1'b0 || ERR_UNF !== 1'b0) begin
        failures++;
        $display("FAIL stream[%0d]: got cnt=%0d dat=%0d ovf=%b unf=%b expected cnt=1 dat=%0d ovf=0 unf=0",
                 i, FO_CNT, FO_DAT, ERR_OVF, ERR_UNF, i - 1);
      end
      step(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
    end
    checks++;
    if (FO_CNT !== 5'd1 || FO_DAT !== 8'd255) begin
      failures++; $display("FAIL stream_end: got cnt=%0d dat=%0d expected cnt=1 dat=255", FO_CNT, FO_DAT);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] w[16];
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      w[i] = 8'($urandom_range(0, 200));
      step(1'b0, 1'b0, 1'b1, w[i], 1'b0);
    end
    checks++;
    if (FI_BSY !== 1'b1 || FO_CNT !== 5'd16) begin
      failures++; $display("FAIL fullpp_pre: got bsy=%b cnt=%0d expected bsy=1 cnt=16", FI_BSY, FO_CNT);
    end
    step(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
    checks++;
    if (FO_CNT !== 5'd15 || ERR_OVF !== 1'b1 || FI_BSY !== 1'b0 || FO_DAT !== w[1]) begin
      failures++;
      $display("FAIL fullpp_post: got cnt=%0d ovf=%b bsy=%b dat=%0h expected cnt=15 ovf=1 bsy=0 dat=%0h",
               FO_CNT, ERR_OVF, FI_BSY, FO_DAT, w[1]);
    end
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (FO_DAT !== w[i]) begin
        failures++; $display("FAIL fullpp_drain[%0d]: got %0h expected %0h", i, FO_DAT, w[i]);
      end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (FO_STB !== 1'b0) begin
      failures++; $display("FAIL fullpp_empty: got stb=%b expected 0 (dropped word stored)", FO_STB);
    end
  endtask

  task automatic test_flush_wrap();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    checks++;
    if (FO_CNT !== 5'd12 || FO_DAT !== 8'h80 || ERR_UNF !== 1'b1) begin
      failures++;
      $display("FAIL wrap_state: got cnt=%0d dat=%0h unf=%b expected cnt=12 dat=80 unf=1", FO_CNT, FO_DAT, ERR_UNF);
    end
    step(1'b0, 1'b1, 1'b1, 8'hAB, 1'b1);
    checks++;
    if (FO_CNT !== 5'd0 || FO_STB !== 1'b0 || ERR_UNF !== 1'b0 || ERR_OVF !== 1'b0 || FO_AEMPTY !== 1'b1) begin
      failures++;
      $display("FAIL flush_state: got cnt=%0d stb=%b unf=%b ovf=%b aempty=%b expected 0 0 0 0 1",
               FO_CNT, FO_STB, ERR_UNF, ERR_OVF, FO_AEMPTY);
    end
    step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    checks++;
    if (FO_CNT !== 5'd1 || FO_STB !== 1'b1 || FO_DAT !== 8'h5A) begin
      failures++;
      $display("FAIL flush_next: got cnt=%0d stb=%b dat=%0h expected cnt=1 stb=1 dat=5a", FO_CNT, FO_STB, FO_DAT);
    end
  endtask

  task automatic test_random();
    int errs_here;
    logic [7:0] exp_dat;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      // Alternate producer-heavy and consumer-heavy phases so both full and empty are visited.
      int wp;
      wp = ((c / 200) % 2 == 0) ? 75 : 30;
      step(1'($urandom_range(0, 999) < 3), 1'($urandom_range(0, 999) < 8),
           1'($urandom_range(0, 99) < wp), 8'($urandom), 1'($urandom_range(0, 99) < 100 - wp + 10));
      exp_dat = (q.size() != 0) ? q[0] : 8'h00;
      errs_here = 0;
      if (FO_CNT !== 5'(q.size()))        errs_here++;
      if (FO_STB !== (q.size() != 0))     errs_here++;
      if (FI_BSY !== (q.size() == 16))    errs_here++;
      if (FI_AFULL !== (q.size() >= 12))  errs_here++;
      if (FO_AEMPTY !== (q.size() <= 2))  errs_here++;
      if (ERR_OVF !== m_ovf)              errs_here++;
      if (ERR_UNF !== m_unf)              errs_here++;
      if (FO_DAT !== exp_dat)             errs_here++;
      checks++;
      if (errs_here != 0) begin
        failures++;
        $display("FAIL random[%0d]: got cnt=%0d stb=%b bsy=%b af=%b ae=%b ovf=%b unf=%b dat=%0h expected cnt=%0d ovf=%b unf=%b dat=%0h",
                 c, FO_CNT, FO_STB, FI_BSY, FI_AFULL, FO_AEMPTY, ERR_OVF, ERR_UNF, FO_DAT,
                 q.size(), m_ovf, m_unf, exp_dat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain();
    test_streaming();
    test_full_push_pop();
    test_flush_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
